// File: rtl/block_stack_pkg.sv
// Shared types, widths and helpers for the block-stacking game row controller.
package block_stack_pkg;

    localparam int unsigned POS_W  = 9;
    localparam int unsigned SIZE_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        MOVE,
        STOP1,
        STOP2,
        COMMIT,
        OVER,
        WON
    } state_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Inclusive right pixel of a block; computed one bit wider so the span cannot wrap.
    function automatic logic [POS_W-1:0] block_end(input logic [POS_W-1:0]  start,
                                                   input logic [SIZE_W-1:0] size,
                                                   input int unsigned       unit_log2);
        logic [POS_W:0] span;
        span = {1'b0, start} + ({{(POS_W + 1 - SIZE_W){1'b0}}, size} << unit_log2)
               - {{POS_W{1'b0}}, 1'b1};
        return span[POS_W-1:0];
    endfunction

endpackage

// File: rtl/step_timer.sv
// Free-running tick generator: one tick every period_i enabled cycles, clearable.
module step_timer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic [23:0] period_i,
    output logic        tick_o
);

    logic [23:0] count_q, count_d;
    logic        at_end;

    assign at_end = (count_q >= period_i - 24'd1);

    always_comb begin
        count_d = count_q;
        tick_o  = 1'b0;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            if (at_end) begin
                tick_o  = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + 24'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/block_row_controller.sv
// Moves the current block, hands it to the intersection checker on stop, and
// commits the trimmed overlap as the new previous row.
module block_row_controller
    import block_stack_pkg::*;
#(
    parameter logic [8:0]  X_MIN          = 9'd8,
    parameter logic [8:0]  X_MAX          = 9'd311,
    parameter int unsigned UNIT_LOG2      = 3,
    parameter logic [3:0]  INIT_SIZE      = 4'd3,
    parameter logic [3:0]  ROWS           = 4'd12,
    parameter logic [23:0] TICKS_PER_STEP = 24'd2_500_000,
    parameter logic [23:0] SPEEDUP        = 24'd100_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start_game,
    input  logic       stop_btn,
    input  logic       intersect_true,
    output logic       stop_true,
    output logic [8:0] curr_block_start,
    output logic [8:0] curr_block_end,
    output logic [3:0] curr_block_size,
    output logic [8:0] prev_block_start,
    output logic [8:0] prev_block_end,
    output logic [3:0] prev_block_size,
    output logic [3:0] row,
    output logic       draw_req,
    output logic       game_over,
    output logic       game_won
);

    localparam logic [POS_W:0] UNIT = (POS_W + 1)'(1 << UNIT_LOG2);

    state_e             state_q, state_d;
    logic               dir_q, dir_d;
    logic [POS_W-1:0]   curr_start_q, curr_start_d;
    logic [POS_W-1:0]   curr_end_q, curr_end_d;
    logic [SIZE_W-1:0]  curr_size_q, curr_size_d;
    logic [POS_W-1:0]   prev_start_q, prev_start_d;
    logic [POS_W-1:0]   prev_end_q, prev_end_d;
    logic [SIZE_W-1:0]  prev_size_q, prev_size_d;
    logic [3:0]         row_q, row_d;
    logic               over_q, over_d;
    logic               won_q, won_d;

    logic               tick;
    logic               timer_clear;
    logic [23:0]        period;
    logic [27:0]        slow_prod;
    logic [28:0]        period_diff;

    logic [POS_W:0]     end_plus;
    logic [POS_W:0]     start_plus;
    logic [POS_W:0]     start_minus;
    logic               can_right;
    logic               can_left;

    logic               no_prev;
    logic [POS_W-1:0]   new_end;
    logic [POS_W:0]     new_span;
    logic [POS_W:0]     new_units;
    logic [SIZE_W-1:0]  new_size;
    logic               unused_bits;

    // Period shrinks per row; a negative or tiny result saturates at the floor of 4.
    assign slow_prod   = 28'(row_q) * 28'(SPEEDUP);
    assign period_diff = {5'd0, TICKS_PER_STEP} - {1'b0, slow_prod};
    assign period      = (period_diff[28] || (period_diff[27:0] < 28'd4)) ? 24'd4
                                                                          : period_diff[23:0];

    step_timer u_step_timer (
        .clk      (clk),
        .resetn   (resetn),
        .clear_i  (timer_clear),
        .enable_i (state_q == MOVE),
        .period_i (period),
        .tick_o   (tick)
    );

    assign end_plus    = {1'b0, curr_end_q} + UNIT;
    assign start_plus  = {1'b0, curr_start_q} + UNIT;
    assign start_minus = {1'b0, curr_start_q} - UNIT;
    assign can_right   = (end_plus <= {1'b0, X_MAX});
    assign can_left    = ({1'b0, curr_start_q} >= ({1'b0, X_MIN} + UNIT));

    assign no_prev   = (prev_start_q == '0) && (prev_end_q == '0);
    assign new_end   = (no_prev || (curr_end_q < prev_end_q)) ? curr_end_q : prev_end_q;
    assign new_span  = {1'b0, new_end} - {1'b0, curr_start_q} + {{POS_W{1'b0}}, 1'b1};
    assign new_units = new_span >> UNIT_LOG2;
    assign new_size  = new_units[SIZE_W-1:0];

    assign unused_bits = ^{new_units[POS_W:SIZE_W], period_diff[27:24]};

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        curr_start_d = curr_start_q;
        curr_end_d   = curr_end_q;
        curr_size_d  = curr_size_q;
        prev_start_d = prev_start_q;
        prev_end_d   = prev_end_q;
        prev_size_d  = prev_size_q;
        row_d        = row_q;
        over_d       = over_q;
        won_d        = won_q;
        timer_clear  = 1'b0;

        unique case (state_q)
            IDLE, OVER, WON: begin
                if (start_game) begin
                    curr_start_d = X_MIN;
                    curr_size_d  = INIT_SIZE;
                    curr_end_d   = block_end(X_MIN, INIT_SIZE, UNIT_LOG2);
                    prev_start_d = '0;
                    prev_end_d   = '0;
                    prev_size_d  = '0;
                    row_d        = '0;
                    dir_d        = DIR_RIGHT;
                    over_d       = 1'b0;
                    won_d        = 1'b0;
                    timer_clear  = 1'b1;
                    state_d      = MOVE;
                end
            end
            MOVE: begin
                // A stop that lands on a tick wins; the block freezes where it was.
                if (stop_btn) begin
                    state_d = STOP1;
                end else if (tick) begin
                    if (dir_q == DIR_RIGHT) begin
                        if (can_right) begin
                            curr_start_d = start_plus[POS_W-1:0];
                        end else if (can_left) begin
                            dir_d        = DIR_LEFT;
                            curr_start_d = start_minus[POS_W-1:0];
                        end
                    end else begin
                        if (can_left) begin
                            curr_start_d = start_minus[POS_W-1:0];
                        end else if (can_right) begin
                            dir_d        = DIR_RIGHT;
                            curr_start_d = start_plus[POS_W-1:0];
                        end
                    end
                    curr_end_d = block_end(curr_start_d, curr_size_q, UNIT_LOG2);
                end
            end
            STOP1: begin
                state_d = STOP2;
            end
            STOP2: begin
                if (intersect_true) begin
                    state_d = COMMIT;
                end else begin
                    over_d  = 1'b1;
                    state_d = OVER;
                end
            end
            COMMIT: begin
                prev_start_d = curr_start_q;
                prev_end_d   = new_end;
                prev_size_d  = new_size;
                row_d        = row_q + 4'd1;
                if ((row_q + 4'd1) == ROWS) begin
                    won_d   = 1'b1;
                    state_d = WON;
                end else begin
                    curr_size_d  = new_size;
                    curr_start_d = X_MIN;
                    curr_end_d   = block_end(X_MIN, new_size, UNIT_LOG2);
                    dir_d        = DIR_RIGHT;
                    timer_clear  = 1'b1;
                    state_d      = MOVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            dir_q        <= DIR_RIGHT;
            curr_start_q <= '0;
            curr_end_q   <= '0;
            curr_size_q  <= '0;
            prev_start_q <= '0;
            prev_end_q   <= '0;
            prev_size_q  <= '0;
            row_q        <= '0;
            over_q       <= 1'b0;
            won_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            curr_start_q <= curr_start_d;
            curr_end_q   <= curr_end_d;
            curr_size_q  <= curr_size_d;
            prev_start_q <= prev_start_d;
            prev_end_q   <= prev_end_d;
            prev_size_q  <= prev_size_d;
            row_q        <= row_d;
            over_q       <= over_d;
            won_q        <= won_d;
        end
    end

    assign stop_true        = (state_q == STOP1) || (state_q == STOP2);
    assign draw_req         = (state_q == COMMIT);
    assign curr_block_start = curr_start_q;
    assign curr_block_end   = curr_end_q;
    assign curr_block_size  = curr_size_q;
    assign prev_block_start = prev_start_q;
    assign prev_block_end   = prev_end_q;
    assign prev_block_size  = prev_size_q;
    assign row              = row_q;
    assign game_over        = over_q;
    assign game_won         = won_q;

endmodule

// File: tb/tb_block_row_controller.sv
// Directed bench for block_row_controller with a registered intersection checker model.
module tb_block_row_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn, start_game, stop_btn, intersect_true;
    logic       stop_true, draw_req, game_over, game_won;
    logic [8:0] curr_block_start, curr_block_end, prev_block_start, prev_block_end;
    logic [3:0] curr_block_size, prev_block_size, row;

    logic       start2, stop2, isect2;
    logic       stop_true2, draw_req2, game_over2, game_won2;
    logic [8:0] cs2, ce2, ps2, pe2;
    logic [3:0] csz2, psz2, row2;

    int n_checks = 0;
    int n_fail   = 0;

    block_row_controller #(
        .TICKS_PER_STEP (24'd4),
        .SPEEDUP        (24'd0)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .start_game       (start_game),
        .stop_btn         (stop_btn),
        .intersect_true   (intersect_true),
        .stop_true        (stop_true),
        .curr_block_start (curr_block_start),
        .curr_block_end   (curr_block_end),
        .curr_block_size  (curr_block_size),
        .prev_block_start (prev_block_start),
        .prev_block_end   (prev_block_end),
        .prev_block_size  (prev_block_size),
        .row              (row),
        .draw_req         (draw_req),
        .game_over        (game_over),
        .game_won         (game_won)
    );

    block_row_controller #(
        .ROWS           (4'd2),
        .TICKS_PER_STEP (24'd4),
        .SPEEDUP        (24'd0)
    ) dut2 (
        .clk              (clk),
        .resetn           (resetn),
        .start_game       (start2),
        .stop_btn         (stop2),
        .intersect_true   (isect2),
        .stop_true        (stop_true2),
        .curr_block_start (cs2),
        .curr_block_end   (ce2),
        .curr_block_size  (csz2),
        .prev_block_start (ps2),
        .prev_block_end   (pe2),
        .prev_block_size  (psz2),
        .row              (row2),
        .draw_req         (draw_req2),
        .game_over        (game_over2),
        .game_won         (game_won2)
    );

    // Checker: registers overlap (or empty previous row) while stop_true is high.
    always @(posedge clk) begin
        if (!resetn) begin
            intersect_true <= 1'b0;
            isect2         <= 1'b0;
        end else begin
            intersect_true <= stop_true && (((prev_block_start == 0) && (prev_block_end == 0))
                              || ((curr_block_start <= prev_block_end)
                                  && (curr_block_end >= prev_block_start)));
            isect2 <= stop_true2 && (((ps2 == 0) && (pe2 == 0)) || ((cs2 <= pe2) && (ce2 >= ps2)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_stop();
        stop_btn = 1'b1;
        step();
        stop_btn = 1'b0;
    endtask

    task automatic wait_pos(input logic [8:0] target, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (curr_block_start === target) begin
                found = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_change(input int budget, output bit found);
        logic [8:0] old;
        old   = curr_block_start;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (curr_block_start !== old) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; start_game = 1'b0; stop_btn = 1'b0; start2 = 1'b0; stop2 = 1'b0;
        step();
        step();
        n_checks++;
        if ({stop_true, draw_req, game_over, game_won, row} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got st=%b dr=%b go=%b gw=%b row=%0d expected all 0",
                     stop_true, draw_req, game_over, game_won, row);
        end
        n_checks++;
        if ({curr_block_start, curr_block_end, curr_block_size} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_curr: got %0d..%0d size %0d expected 0..0 size 0",
                     curr_block_start, curr_block_end, curr_block_size);
        end
        n_checks++;
        if ({prev_block_start, prev_block_end, prev_block_size} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_prev: got %0d..%0d size %0d expected 0..0 size 0",
                     prev_block_start, prev_block_end, prev_block_size);
        end
        resetn = 1'b1;
        step();
        pulse_stop();
        n_checks++;
        if (stop_true !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_stop_ignored: stop_true got %b expected 0", stop_true);
        end
    endtask

    task automatic test_first_row();
        start_game = 1'b1;
        step();
        start_game = 1'b0;
        n_checks++;
        if ({curr_block_start, curr_block_end, curr_block_size, row} !== {9'd8, 9'd31, 4'd3, 4'd0})
        begin
            n_fail++;
            $display("FAIL start_curr: got %0d..%0d size %0d row %0d expected 8..31 size 3 row 0",
                     curr_block_start, curr_block_end, curr_block_size, row);
        end
        pulse_stop();
        n_checks++;
        if ({stop_true, draw_req} !== 2'b10) begin
            n_fail++;
            $display("FAIL first_stop1: got st=%b dr=%b expected st=1 dr=0", stop_true, draw_req);
        end
        step();
        n_checks++;
        if ({stop_true, draw_req} !== 2'b10) begin
            n_fail++;
            $display("FAIL first_stop2: got st=%b dr=%b expected st=1 dr=0", stop_true, draw_req);
        end
        step();
        n_checks++;
        if ({stop_true, draw_req} !== 2'b01) begin
            n_fail++;
            $display("FAIL first_commit: got st=%b dr=%b expected st=0 dr=1", stop_true, draw_req);
        end
        step();
        n_checks++;
        if (draw_req !== 1'b0) begin
            n_fail++;
            $display("FAIL first_draw_once: draw_req got %b expected 0", draw_req);
        end
        n_checks++;
        if ({prev_block_start, prev_block_end, prev_block_size, row} !== {9'd8, 9'd31, 4'd3, 4'd1})
        begin
            n_fail++;
            $display("FAIL first_prev: got %0d..%0d size %0d row %0d expected 8..31 size 3 row 1",
                     prev_block_start, prev_block_end, prev_block_size, row);
        end
        n_checks++;
        if ({curr_block_start, curr_block_end, curr_block_size} !== {9'd8, 9'd31, 4'd3}) begin
            n_fail++;
            $display("FAIL first_restart: got %0d..%0d size %0d expected 8..31 size 3",
                     curr_block_start, curr_block_end, curr_block_size);
        end
    endtask

    task automatic test_miss();
        bit found;
        wait_pos(9'd40, 100, found);
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL miss_reach: start got %0d expected 40 within budget", curr_block_start);
        end
        pulse_stop();
        step();
        step();
        n_checks++;
        if ({game_over, stop_true, draw_req} !== 3'b100) begin
            n_fail++;
            $display("FAIL miss_over: got go=%b st=%b dr=%b expected go=1 st=0 dr=0",
                     game_over, stop_true, draw_req);
        end
        n_checks++;
        if ({prev_block_start, prev_block_end} !== {9'd8, 9'd31}) begin
            n_fail++;
            $display("FAIL miss_prev_kept: got %0d..%0d expected 8..31",
                     prev_block_start, prev_block_end);
        end
        pulse_stop();
        step();
        n_checks++;
        if ({game_over, stop_true} !== 2'b10) begin
            n_fail++;
            $display("FAIL over_stop_ignored: got go=%b st=%b expected go=1 st=0",
                     game_over, stop_true);
        end
        start_game = 1'b1;
        step();
        start_game = 1'b0;
        n_checks++;
        if ({game_over, row, prev_block_start, prev_block_end, curr_block_start, curr_block_end}
            !== {1'b0, 4'd0, 9'd0, 9'd0, 9'd8, 9'd31}) begin
            n_fail++;
            $display("FAIL restart: got go=%b row=%0d prev %0d..%0d curr %0d..%0d expected 0 0 0..0 8..31",
                     game_over, row, prev_block_start, prev_block_end,
                     curr_block_start, curr_block_end);
        end
    endtask

    task automatic test_partial();
        bit found;
        pulse_stop();
        step();
        step();
        step();
        wait_pos(9'd24, 100, found);
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL partial_reach: start got %0d expected 24 within budget",
                     curr_block_start);
        end
        pulse_stop();
        step();
        step();
        step();
        n_checks++;
        if ({prev_block_start, prev_block_end, prev_block_size, row}
            !== {9'd24, 9'd31, 4'd1, 4'd2}) begin
            n_fail++;
            $display("FAIL partial_prev: got %0d..%0d size %0d row %0d expected 24..31 size 1 row 2",
                     prev_block_start, prev_block_end, prev_block_size, row);
        end
        n_checks++;
        if ({curr_block_start, curr_block_end, curr_block_size} !== {9'd8, 9'd15, 4'd1}) begin
            n_fail++;
            $display("FAIL partial_curr: got %0d..%0d size %0d expected 8..15 size 1",
                     curr_block_start, curr_block_end, curr_block_size);
        end
        // 8..15 against 24..31 misses, leaving the game in OVER for the next scenario.
        pulse_stop();
        step();
        step();
        n_checks++;
        if (game_over !== 1'b1) begin
            n_fail++;
            $display("FAIL partial_miss: game_over got %b expected 1", game_over);
        end
    endtask

    task automatic test_bounce();
        bit found;
        start_game = 1'b1;
        step();
        start_game = 1'b0;
        wait_pos(9'd288, 400, found);
        n_checks++;
        if (!found || (curr_block_end !== 9'd311)) begin
            n_fail++;
            $display("FAIL bounce_reach: got %0d..%0d expected 288..311",
                     curr_block_start, curr_block_end);
        end
        wait_change(10, found);
        n_checks++;
        if ({curr_block_start, curr_block_end} !== {9'd280, 9'd303}) begin
            n_fail++;
            $display("FAIL bounce_right_wall: got %0d..%0d expected 280..303",
                     curr_block_start, curr_block_end);
        end
        wait_change(10, found);
        n_checks++;
        if (curr_block_start !== 9'd272) begin
            n_fail++;
            $display("FAIL bounce_dir_left: start got %0d expected 272", curr_block_start);
        end
        wait_pos(9'd8, 400, found);
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL bounce_reach_left: start got %0d expected 8", curr_block_start);
        end
        wait_change(10, found);
        n_checks++;
        if ({curr_block_start, curr_block_end} !== {9'd16, 9'd39}) begin
            n_fail++;
            $display("FAIL bounce_left_wall: got %0d..%0d expected 16..39",
                     curr_block_start, curr_block_end);
        end
        wait_change(10, found);
        n_checks++;
        if (curr_block_start !== 9'd24) begin
            n_fail++;
            $display("FAIL bounce_dir_right: start got %0d expected 24", curr_block_start);
        end
    endtask

    task automatic test_tick_stop();
        // Block just moved to 24; with a 4-cycle period the next tick is 4 edges away.
        step();
        step();
        step();
        stop_btn = 1'b1;
        step();
        stop_btn = 1'b0;
        n_checks++;
        if ({stop_true, curr_block_start} !== {1'b1, 9'd24}) begin
            n_fail++;
            $display("FAIL tick_stop_hold: got st=%b start=%0d expected st=1 start=24",
                     stop_true, curr_block_start);
        end
        step();
        n_checks++;
        if ({stop_true, draw_req, curr_block_start} !== {1'b1, 1'b0, 9'd24}) begin
            n_fail++;
            $display("FAIL tick_stop_2nd: got st=%b dr=%b start=%0d expected 1 0 24",
                     stop_true, draw_req, curr_block_start);
        end
        step();
        n_checks++;
        if ({stop_true, draw_req} !== 2'b01) begin
            n_fail++;
            $display("FAIL tick_stop_commit: got st=%b dr=%b expected st=0 dr=1",
                     stop_true, draw_req);
        end
        step();
        n_checks++;
        if ({prev_block_start, prev_block_end, prev_block_size, row}
            !== {9'd24, 9'd47, 4'd3, 4'd1}) begin
            n_fail++;
            $display("FAIL tick_stop_prev: got %0d..%0d size %0d row %0d expected 24..47 size 3 row 1",
                     prev_block_start, prev_block_end, prev_block_size, row);
        end
    endtask

    task automatic test_reset_in_stop2();
        pulse_stop();
        step();
        n_checks++;
        if (stop_true !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_stop2: stop_true got %b expected 1", stop_true);
        end
        resetn = 1'b0;
        step();
        n_checks++;
        if ({stop_true, draw_req, game_over, game_won, row, curr_block_start, curr_block_end,
             curr_block_size, prev_block_start, prev_block_end, prev_block_size} !== 52'd0) begin
            n_fail++;
            $display("FAIL rst_stop2_outputs: got st=%b dr=%b row=%0d curr %0d..%0d prev %0d..%0d expected all 0",
                     stop_true, draw_req, row, curr_block_start, curr_block_end,
                     prev_block_start, prev_block_end);
        end
        resetn = 1'b1;
        step();
        pulse_stop();
        step();
        n_checks++;
        if ({stop_true, draw_req, curr_block_start} !== 11'd0) begin
            n_fail++;
            $display("FAIL rst_stop2_idle: got st=%b dr=%b start=%0d expected 0 0 0",
                     stop_true, draw_req, curr_block_start);
        end
    endtask

    task automatic test_won();
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        stop2 = 1'b1;
        step();
        stop2 = 1'b0;
        step();
        step();
        step();
        n_checks++;
        if ({row2, game_won2, cs2} !== {4'd1, 1'b0, 9'd8}) begin
            n_fail++;
            $display("FAIL won_row1: got row=%0d gw=%b start=%0d expected 1 0 8",
                     row2, game_won2, cs2);
        end
        stop2 = 1'b1;
        step();
        stop2 = 1'b0;
        step();
        step();
        n_checks++;
        if (draw_req2 !== 1'b1) begin
            n_fail++;
            $display("FAIL won_commit: draw_req got %b expected 1", draw_req2);
        end
        step();
        n_checks++;
        if ({game_won2, row2, ps2, pe2, psz2} !== {1'b1, 4'd2, 9'd8, 9'd31, 4'd3}) begin
            n_fail++;
            $display("FAIL won_state: got gw=%b row=%0d prev %0d..%0d size %0d expected 1 2 8..31 3",
                     game_won2, row2, ps2, pe2, psz2);
        end
        step();
        n_checks++;
        if ({game_won2, draw_req2, stop_true2} !== 3'b100) begin
            n_fail++;
            $display("FAIL won_hold: got gw=%b dr=%b st=%b expected 1 0 0",
                     game_won2, draw_req2, stop_true2);
        end
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        n_checks++;
        if ({game_won2, row2, cs2} !== {1'b0, 4'd0, 9'd8}) begin
            n_fail++;
            $display("FAIL won_restart: got gw=%b row=%0d start=%0d expected 0 0 8",
                     game_won2, row2, cs2);
        end
    endtask

    initial begin
        test_reset();
        test_first_row();
        test_miss();
        test_partial();
        test_bounce();
        test_tick_stop();
        test_reset_in_stop2();
        test_won();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule

// File: doc/block_row_controller.md
Name: block_row_controller

Overview:
- Game-side driver of the intersection checker. It generates the moving block, latches it on the stop button, and drives stop_true plus the current/previous block geometry. It then samples intersect_true.
- On a hit it trims the new block to the overlap, commits that block as the previous row, and advances to the next row. On a miss it declares game over.
- Sits between the button synchroniser and the VGA draw path. It feeds the checker and pulses draw_req per committed row.

Parameters:
- X_MIN, 9'd8: leftmost playfield pixel. Must be ≥1, so a live block never reads as the 0/0 "no previous row" code.
- X_MAX, 9'd311: rightmost playfield pixel, inclusive.
- UNIT_LOG2, 3: block unit width = 2^UNIT_LOG2 pixels; this is also the move step.
- INIT_SIZE, 4'd3: starting block size in units; 1..15.
- ROWS, 4'd12: rows needed to win; ≤15.
- TICKS_PER_STEP, 24'd2_500_000: clk cycles per move step on row 0.
- SPEEDUP, 24'd100_000: period reduction per row. Period floor is 24'd4.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset
- start_game  in  1  one-cycle pulse; starts a new game
- stop_btn  in  1  one-cycle pulse, already synchronised/debounced
- intersect_true  in  1  registered checker result
- stop_true  out  1  high while the checker evaluates
- curr_block_start  out  9  moving block left pixel
- curr_block_end  out  9  moving block right pixel, inclusive
- curr_block_size  out  4  moving block size in units
- prev_block_start  out  9  committed row left pixel; 0 when no row
- prev_block_end  out  9  committed row right pixel; 0 when no row
- prev_block_size  out  4  committed size in units
- row  out  4  current row index
- draw_req  out  1  one-cycle pulse when a row commits
- game_over  out  1  level, miss
- game_won  out  1  level, ROWS committed

Behaviour:
- Reset: resetn, synchronous, active-low; clock clk. Reset overrides everything, including mid-STOP.
  - All outputs go to 0.
  - State goes to IDLE, dir to right, tick counter to 0.
- Invariant: curr_block_end = curr_block_start + (curr_block_size << UNIT_LOG2) - 1. It is recomputed whenever start or size changes.
- IDLE / OVER / WON:
  - start_game loads curr_start = X_MIN, curr_size = INIT_SIZE, prev = 0/0/0, row = 0, dir = right.
  - It also clears game_over/game_won and the tick counter, then enters MOVE.
  - stop_btn is ignored in these states.
- MOVE:
  - The tick counter counts to period-1, then emits a tick and wraps.
  - period = max(TICKS_PER_STEP - row*SPEEDUP, 4).
  - On a tick with dir = right:
    - If curr_end + UNIT ≤ X_MAX, move start +UNIT.
    - Otherwise set dir = left and move -UNIT, if curr_start - UNIT ≥ X_MIN.
  - The left direction is symmetric.
  - If neither move is legal, the block holds.
  - stop_btn goes to STOP1. If it coincides with a tick, the tick is dropped and the position is unchanged.
  - start_game is ignored.
- STOP1: stop_true = 1; the checker samples at the closing edge. Next state is STOP2.
- STOP2: stop_true = 1; intersect_true is sampled at the closing edge.
  - 1 → COMMIT.
  - 0 → OVER with game_over = 1.
- COMMIT (one cycle; stop_true = 0, draw_req = 1):
  - new_start = curr_start.
  - new_end = curr_end if prev is 0/0, otherwise min(curr_end, prev_end).
  - new_size = (new_end - new_start + 1) >> UNIT_LOG2. This is exact because positions are unit-aligned relative to X_MIN.
  - prev ← new values; row ← row + 1.
  - If row + 1 == ROWS → WON with game_won = 1.
  - Otherwise curr_size ← new_size, curr_start ← X_MIN, dir ← right, tick counter cleared, → MOVE.
- Total stop-to-commit latency: 3 cycles after the stop_btn edge.
- Width rules:
  - Compute position sums in 10 bits so that +UNIT cannot wrap before the X_MAX compare.
  - Compute the row*SPEEDUP product at 28 bits, then saturate.

Decomposition:
- Package block_stack_pkg:
  - state enum {IDLE, MOVE, STOP1, STOP2, COMMIT, OVER, WON}
  - direction constants
  - POS_W = 9, SIZE_W = 4
  - the end-from-size helper function
- One sub-module, step_timer: the tick counter with programmable period, a clear input, and an enable input.

Test Plan (X_MIN=8, X_MAX=311, UNIT_LOG2=3, INIT_SIZE=3, TICKS_PER_STEP=4, SPEEDUP=0, checker instantiated):
- Start, stop at curr 8..31:
  - prev 0/0 so the hit is automatic.
  - After COMMIT: prev = 8..31 size 3, row = 1, draw_req high exactly 1 cycle, curr restarts at 8..31.
- Partial overlap: with prev 8..31, stop at curr 24..47.
  - Hit → prev = 24..31, size 1, curr restarts at 8..15.
- Miss: with prev 8..31, stop at curr 40..63.
  - Checker gives 0 → game_over = 1, state OVER.
  - A later stop_btn is ignored; start_game restarts at row 0.
- Bounce: size 3 at 288..311.
  - Next tick → 280..303 with dir left.
  - Later, at 8..31, the next tick → 16..39.
- stop_btn in the same cycle as a tick: position stays unchanged, stop_true is high for exactly 2 cycles, and the result commits on the 3rd.
- resetn low during STOP2: all outputs 0 next cycle, state IDLE. With ROWS=2, two aligned hits → game_won = 1.
